// File: rtl/bram_addr_gen_if.sv
// Handshake and status bundle between the write-enable generator, the conv datapath and
// the line-buffer address controller.
interface bram_addr_gen_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              we;
  logic              wen;
  logic              irval;
  logic [ADDR_W-1:0] owaddr;
  logic [ADDR_W-1:0] oraddr;
  logic              oren;
  logic              ordval;
  logic [ADDR_W:0]   ocount;
  logic              ofull;
  logic              oempty;
  logic [ADDR_W-1:0] ocol;
  logic [ADDR_W-1:0] orow;
  logic              owin_rdy;
  logic              oovf;

  modport master (
    output we, wen, irval,
    input  owaddr, oraddr, oren, ordval, ocount, ofull, oempty, ocol, orow, owin_rdy, oovf
  );

  modport slave (
    input  we, wen, irval,
    output owaddr, oraddr, oren, ordval, ocount, ofull, oempty, ocol, orow, owin_rdy, oovf
  );
endinterface

// File: rtl/bram_addr_gen.sv
// Ring-buffer address/occupancy controller for the ip_conv input line buffer. Tracks fill
// level and image position, and flags when a full KROWS x KROWS window is buffered.
module bram_addr_gen #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned KROWS  = 3
) (
  input logic            clk,
  input logic            rstn,
  bram_addr_gen_if.slave bus
);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WIN_TH = (KROWS - 1) * IMG_W + KROWS;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_WIN  = CNT_W'(WIN_TH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ren_q, rdval_q;
  logic              full_q, empty_q, win_q, ovf_q;
  logic              ovf_d;
  logic              wr_req, wr_acc, rd_acc;

  always_comb begin
    wr_req  = bus.we & bus.wen;
    wr_acc  = wr_req & ~full_q;
    rd_acc  = bus.irval & ~empty_q;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    raddr_d = raddr_q;
    col_d   = col_q;
    row_d   = row_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr_req & full_q);

    if (wr_acc) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (rd_acc) begin
      raddr_d = rptr_q;
      rptr_d  = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flags decode the next count so they line up with the registered ocount.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      raddr_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      count_q <= '0;
      ren_q   <= 1'b0;
      rdval_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      win_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      raddr_q <= raddr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      count_q <= count_d;
      ren_q   <= rd_acc;
      rdval_q <= ren_q;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
      win_q   <= (count_d >= CNT_WIN);
      ovf_q   <= ovf_d;
    end
  end

  assign bus.owaddr   = wptr_q;
  assign bus.oraddr   = raddr_q;
  assign bus.oren     = ren_q;
  assign bus.ordval   = rdval_q;
  assign bus.ocount   = count_q;
  assign bus.ofull    = full_q;
  assign bus.oempty   = empty_q;
  assign bus.ocol     = col_q;
  assign bus.orow     = row_q;
  assign bus.owin_rdy = win_q;
  assign bus.oovf     = ovf_q;
endmodule

// File: tb/tb_bram_addr_gen.sv
// Self-checking bench for bram_addr_gen: directed scenarios plus randomized traffic
// checked against a queue-based model of the ring buffer.
module tb_bram_addr_gen;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned IMG_W  = 4;
  localparam int unsigned KROWS  = 2;
  localparam int unsigned WIN_TH = (KROWS - 1) * IMG_W + KROWS;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  bram_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

  bram_addr_gen #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .IMG_W (IMG_W),
    .KROWS (KROWS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: queue holds the BRAM addresses of stored entries, oldest first.
  int m_nwr;
  int m_q[$];
  bit m_oren, m_ordval, m_ovf;
  int m_oraddr;

  task automatic model_clear();
    m_nwr = 0; m_q.delete(); m_oren = 0; m_ordval = 0; m_ovf = 0; m_oraddr = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit c);
    int sz;
    bit wr, rd;
    sz = m_q.size();
    wr = a && b && (sz != DEPTH);
    rd = c && (sz != 0);
    if (a && b && sz == DEPTH) m_ovf = 1;
    m_ordval = m_oren;
    m_oren   = rd;
    if (rd) m_oraddr = m_q.pop_front();
    if (wr) begin
      m_q.push_back(m_nwr % DEPTH);
      m_nwr++;
    end
  endtask

  task automatic step(input bit a, input bit b, input bit c);
    bus.we = a; bus.wen = b; bus.irval = c;
    model_step(a, b, c);
    @(posedge clk); #1;
    bus.we = 0; bus.wen = 0; bus.irval = 0;
  endtask

  task automatic do_reset();
    bus.we = 0; bus.wen = 0; bus.irval = 0;
    rstn = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.owaddr !== 0) begin n_err++; $display("FAIL rst_owaddr got %0d want 0", bus.owaddr); end
    n_checks++; if (bus.ocount !== 0) begin n_err++; $display("FAIL rst_ocount got %0d want 0", bus.ocount); end
    n_checks++; if (bus.oempty !== 1'b1) begin n_err++; $display("FAIL rst_oempty got %b want 1", bus.oempty); end
    n_checks++; if (bus.ofull !== 1'b0) begin n_err++; $display("FAIL rst_ofull got %b want 0", bus.ofull); end
    n_checks++; if (bus.oren !== 1'b0 || bus.ordval !== 1'b0) begin
      n_err++; $display("FAIL rst_oren_ordval got %b%b want 00", bus.oren, bus.ordval); end
    n_checks++; if (bus.ocol !== 0 || bus.orow !== 0) begin
      n_err++; $display("FAIL rst_col_row got %0d/%0d want 0/0", bus.ocol, bus.orow); end
    n_checks++; if (bus.owin_rdy !== 1'b0 || bus.oovf !== 1'b0 || bus.oraddr !== 0) begin
      n_err++; $display("FAIL rst_misc got win=%b ovf=%b raddr=%0d want 0", bus.owin_rdy, bus.oovf,
                        bus.oraddr); end
  endtask

  task automatic test_fill_three();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.owaddr !== i) begin
        n_err++; $display("FAIL fill3_owaddr got %0d want %0d", bus.owaddr, i); end
      step(1, 1, 0);
      if (i == 0) begin
        n_checks++; if (bus.oempty !== 1'b0) begin
          n_err++; $display("FAIL fill3_oempty got %b want 0", bus.oempty); end
      end
    end
    n_checks++; if (bus.ocount !== 3) begin n_err++; $display("FAIL fill3_ocount got %0d want 3", bus.ocount); end
    n_checks++; if (bus.ocol !== 3 || bus.orow !== 0) begin
      n_err++; $display("FAIL fill3_col_row got %0d/%0d want 3/0", bus.ocol, bus.orow); end
  endtask

  task automatic test_full_ovf();
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    n_checks++; if (bus.ocount !== 0) begin n_err++; $display("FAIL lone_strobe got %0d want 0", bus.ocount); end
    repeat (8) step(1, 1, 0);
    n_checks++; if (bus.ocount !== 8 || bus.ofull !== 1'b1) begin
      n_err++; $display("FAIL full_cnt got %0d/%b want 8/1", bus.ocount, bus.ofull); end
    n_checks++; if (bus.owaddr !== 0 || bus.ocol !== 0 || bus.orow !== 2) begin
      n_err++; $display("FAIL full_pos got waddr=%0d col=%0d row=%0d want 0/0/2", bus.owaddr,
                        bus.ocol, bus.orow); end
    n_checks++; if (bus.oovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", bus.oovf); end
    step(1, 1, 0);
    n_checks++; if (bus.ocount !== 8 || bus.oovf !== 1'b1 || bus.owaddr !== 0 || bus.ocol !== 0) begin
      n_err++; $display("FAIL ovf_set got cnt=%0d ovf=%b waddr=%0d col=%0d want 8/1/0/0", bus.ocount,
                        bus.oovf, bus.owaddr, bus.ocol); end
    repeat (3) step(0, 0, 1);
    n_checks++; if (bus.oovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", bus.oovf); end
  endtask

  task automatic test_window();
    do_reset();
    repeat (5) step(1, 1, 0);
    n_checks++; if (bus.ocount !== 5 || bus.owin_rdy !== 1'b0) begin
      n_err++; $display("FAIL win_5 got %0d/%b want 5/0", bus.ocount, bus.owin_rdy); end
    step(1, 1, 0);
    n_checks++; if (bus.ocount !== 6 || bus.owin_rdy !== 1'b1) begin
      n_err++; $display("FAIL win_6 got %0d/%b want 6/1", bus.ocount, bus.owin_rdy); end
    step(0, 0, 1);
    n_checks++; if (bus.ocount !== 5 || bus.owin_rdy !== 1'b0) begin
      n_err++; $display("FAIL win_fall got %0d/%b want 5/0", bus.ocount, bus.owin_rdy); end
  endtask

  task automatic test_read();
    do_reset();
    repeat (3) step(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      n_checks++; if (bus.oren !== 1'b1 || bus.oraddr !== i) begin
        n_err++; $display("FAIL rd_%0d got oren=%b raddr=%0d want 1/%0d", i, bus.oren, bus.oraddr, i); end
      n_checks++; if (bus.ordval !== (i != 0)) begin
        n_err++; $display("FAIL rdval_%0d got %b want %b", i, bus.ordval, i != 0); end
    end
    step(0, 0, 1);
    n_checks++; if (bus.oren !== 1'b0 || bus.oempty !== 1'b1 || bus.ordval !== 1'b1) begin
      n_err++; $display("FAIL rd_empty got oren=%b empty=%b rdval=%b want 0/1/1", bus.oren,
                        bus.oempty, bus.ordval); end
    step(0, 0, 0);
    n_checks++; if (bus.ordval !== 1'b0) begin n_err++; $display("FAIL rdval_end got %b want 0", bus.ordval); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1, 1, 1);
    n_checks++; if (bus.ocount !== 1 || bus.oren !== 1'b0) begin
      n_err++; $display("FAIL sim_empty got cnt=%0d oren=%b want 1/0", bus.ocount, bus.oren); end
    step(0, 0, 1);
    repeat (8) step(1, 1, 0);
    step(1, 1, 1);
    n_checks++; if (bus.ocount !== 7 || bus.oovf !== 1'b1 || bus.oren !== 1'b1 || bus.oraddr !== 1) begin
      n_err++; $display("FAIL sim_full got cnt=%0d ovf=%b oren=%b raddr=%0d want 7/1/1/1", bus.ocount,
                        bus.oovf, bus.oren, bus.oraddr); end
    n_checks++; if (bus.owaddr !== 1) begin n_err++; $display("FAIL sim_full_waddr got %0d want 1", bus.owaddr); end
    repeat (3) step(0, 0, 1);
    step(1, 1, 1);
    n_checks++; if (bus.ocount !== 4 || bus.oraddr !== 5 || bus.owaddr !== 2) begin
      n_err++; $display("FAIL sim_mid got cnt=%0d raddr=%0d waddr=%0d want 4/5/2", bus.ocount,
                        bus.oraddr, bus.owaddr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (6) step(1, 1, 0);
    step(0, 0, 1);
    n_checks++; if (bus.ocount !== 5 || bus.oren !== 1'b1) begin
      n_err++; $display("FAIL ar_pre got cnt=%0d oren=%b want 5/1", bus.ocount, bus.oren); end
    bus.we = 1; bus.wen = 1; bus.irval = 1;
    #2 rstn = 0;
    #1;
    n_checks++; if (bus.ocount !== 0 || bus.oempty !== 1'b1 || bus.oren !== 1'b0 ||
                    bus.owaddr !== 0 || bus.ocol !== 0 || bus.owin_rdy !== 1'b0) begin
      n_err++; $display("FAIL async_rst got cnt=%0d empty=%b oren=%b waddr=%0d col=%0d win=%b",
                        bus.ocount, bus.oempty, bus.oren, bus.owaddr, bus.ocol, bus.owin_rdy); end
    bus.we = 0; bus.wen = 0; bus.irval = 0;
    model_clear();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    n_checks++; if (bus.ordval !== 1'b0 || bus.ocount !== 0) begin
      n_err++; $display("FAIL ar_post got rdval=%b cnt=%0d want 0/0", bus.ordval, bus.ocount); end
  endtask

  task automatic test_random();
    int wp, rp, er;
    bit a, b, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Phases bias traffic toward filling, draining or balanced.
      case ((i / 75) % 3)
        0:       begin wp = 90; rp = 20; end
        1:       begin wp = 20; rp = 90; end
        default: begin wp = 60; rp = 60; end
      endcase
      a = ($urandom_range(0, 99) < wp);
      b = a ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 99) < rp);
      n_checks++; if (bus.owaddr !== (m_nwr % DEPTH)) begin
        n_err++; $display("FAIL rnd_owaddr @%0d got %0d want %0d", i, bus.owaddr, m_nwr % DEPTH); end
      step(a, b, c);
      er = 0;
      if (bus.ocount !== m_q.size()) er++;
      if (bus.ofull !== (m_q.size() == DEPTH)) er++;
      if (bus.oempty !== (m_q.size() == 0)) er++;
      if (bus.owin_rdy !== (m_q.size() >= WIN_TH)) er++;
      if (bus.ocol !== (m_nwr % IMG_W)) er++;
      if (bus.orow !== ((m_nwr / IMG_W) % (1 << ADDR_W))) er++;
      if (bus.oren !== m_oren || bus.ordval !== m_ordval || bus.oovf !== m_ovf) er++;
      if (m_oren && bus.oraddr !== m_oraddr) er++;
      n_checks++;
      if (er != 0) begin
        n_err++;
        $display("FAIL rnd_state @%0d got cnt=%0d f=%b e=%b w=%b col=%0d row=%0d ren=%b rv=%b ovf=%b ra=%0d want cnt=%0d col=%0d row=%0d ren=%b rv=%b ovf=%b ra=%0d",
                 i, bus.ocount, bus.ofull, bus.oempty, bus.owin_rdy, bus.ocol, bus.orow, bus.oren,
                 bus.ordval, bus.oovf, bus.oraddr, m_q.size(), m_nwr % IMG_W,
                 (m_nwr / IMG_W) % (1 << ADDR_W), m_oren, m_ordval, m_ovf, m_oraddr);
      end
    end
  endtask

  initial begin
    bus.we = 0; bus.wen = 0; bus.irval = 0;
    model_clear();
    test_reset();
    test_fill_three();
    test_full_ovf();
    test_window();
    test_read();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
